// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that streams operands one nibble per clock
// through a single 4-bit ripple-carry adder, LSB nibble first.

module fourBitRCA (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
        Cout = c[4];
    end
endmodule

module nibble_serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Ovf
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-5:0] sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    logic [3:0]       rca_sum;
    logic             rca_cout;
    logic [WIDTH-1:0] sum_next;
    logic             accept;
    logic             last;

    fourBitRCA u_rca (
        .A    (a_q[3:0]),
        .B    (b_q[3:0]),
        .Cin  (carry_q),
        .Sum  (rca_sum),
        .Cout (rca_cout)
    );

    // New nibble enters at the top so the LSB nibble ends up at bit 0 after NIB shifts.
    assign sum_next = {rca_sum, sum_q};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = (state_q == StRun) && (idx_q == IW'(NIB - 1));
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            Result  <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            sum_q   <= sum_next[WIDTH-1:4];
            carry_q <= rca_cout;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                // On the last nibble a_q/b_q[3] hold the operand sign bits.
                Result <= sum_next;
                Cout   <= rca_cout;
                Ovf    <= (a_q[3] == b_q[3]) && (rca_sum[3] != a_q[3]);
            end
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed corner cases, mid-run start and reset,
// back-to-back operations and a random sweep against an arithmetic reference.

module tb_nibble_serial_addsub;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Ovf;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_res  = '0;
    logic             exp_cout = 1'b0;
    logic             exp_ovf  = 1'b0;

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Cout   (Cout),
        .Ovf    (Ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         output logic [WIDTH-1:0] r, output logic c, output logic o);
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = s ? sa - sb : sa + sb;
        r  = s ? a - b : a + b;
        c  = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        o  = (sr > 32767) || (sr < -32768);
    endtask

    // Drives start now (caller picks the moment), then waits for done.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input bit glitch, input string tag);
        logic [WIDTH-1:0] er;
        logic             ec, eo;
        int               cycles;
        model(a, b, s, er, ec, eo);
        start = 1'b1;
        A     = a;
        B     = b;
        sub   = s;
        @(posedge clk);
        #1;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_done0"}, 32'(done), 32'd0);
        chk({tag, "_hold0"}, 32'(Result), 32'(exp_res));
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (glitch && i == 1) begin
                start = 1'b1;
                sub   = ~s;
            end else begin
                start = 1'b0;
                sub   = 1'($urandom);
            end
            A = 16'($urandom);
            B = 16'($urandom);
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
            chk({tag, "_hold"}, 32'(Result), 32'(exp_res));
        end
        chk({tag, "_latency"}, 32'(cycles), 32'(NIB));
        chk({tag, "_res"}, 32'(Result), 32'(er));
        chk({tag, "_cout"}, 32'(Cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(Ovf), 32'(eo));
        exp_res  = er;
        exp_cout = ec;
        exp_ovf  = eo;
    endtask

    task automatic expect_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(Result), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "t1");
        chk("t1_const", 32'(Result), 32'h2233);
        expect_idle("t1");
        @(negedge clk);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t2");
        chk("t2_const_cout", 32'(Cout), 32'd1);
        expect_idle("t2");
        @(negedge clk);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t3a");
        chk("t3a_const_ovf", 32'(Ovf), 32'd1);
        expect_idle("t3a");
        @(negedge clk);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "t3b");
        chk("t3b_const", 32'(Result), 32'h7FFF);
        expect_idle("t3b");
        @(negedge clk);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, "t4");
        chk("t4_const", 32'(Result), 32'hFFFE);
        expect_idle("t4");

        // Start pulsed mid-run must be ignored.
        @(negedge clk);
        run_op(16'hA5A5, 16'h1111, 1'b0, 1'b1, "t5a");
        expect_idle("t5a");

        // Back-to-back: start asserted during the done cycle.
        @(negedge clk);
        run_op(16'h4000, 16'h4000, 1'b0, 1'b0, "t5b1");
        run_op(16'h0100, 16'h0200, 1'b1, 1'b0, "t5b2");
        expect_idle("t5b2");

        // Reset while idx == 2.
        @(negedge clk);
        start = 1'b1;
        A     = 16'h1357;
        B     = 16'h2468;
        sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_res", 32'(Result), 32'd0);
        chk("t6_cout", 32'(Cout), 32'd0);
        chk("t6_ovf", 32'(Ovf), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("t6_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst      = 1'b0;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        @(negedge clk);
        run_op(16'h1357, 16'h2468, 1'b0, 1'b0, "t6_after");
        expect_idle("t6_after");

        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd");
        end
        expect_idle("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
